accum_sched: RTL and testbench
==============================

ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have, for N=0 and N=1, port reqN_valid  in  1  requester N offers an operand beat.
REQ-005 SHALL have, for N=0 and N=1, port reqN_ready  out  1  beat accepted when valid&ready.
REQ-006 SHALL have, for N=0 and N=1, port reqN_data  in  DATA_W  operand.
REQ-007 SHALL have, for N=0 and N=1, port reqN_len  in  2  operands in the transaction (1-3); sampled at grant.
REQ-008 SHALL have port acc_put  out  1  put strobe to the 3-slot accumulator.
REQ-009 SHALL have port acc_value  out  DATA_W  operand to the accumulator.
REQ-010 SHALL have ports acc_r0, acc_r1, acc_r2  in  DATA_W  accumulator slot outputs.
REQ-011 SHALL have port op_valid  out  1  operand set available.
REQ-012 SHALL have port op_ready  in  1  consumer accepts; transfer on op_valid&op_ready.
REQ-013 SHALL have ports op_a, op_b, op_c  out  DATA_W  captured slots 0/1/2.
REQ-014 SHALL have port op_count  out  2  valid operands in the set (1-3).
REQ-015 SHALL have port op_src  out  1  requester that supplied the set.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM, DRAIN, CAPTURE, PRESENT.
REQ-018 IDLE: if any reqN_valid, SHALL grant one requester, latch its reqN_len as len (0 treated as 1), enter LOAD; reqN_ready low in IDLE.
REQ-019 Arbitration SHALL be round-robin: single requester wins; when both valid, requester not granted last wins; after reset requester 0 has priority.
REQ-020 LOAD: reqN_ready SHALL be high only for the granted requester; each accepted beat written to internal buffer slot 0..len-1.
REQ-021 LOAD SHALL tolerate valid gaps (wait, no timeout); the other requester is never ready during LOAD.
REQ-022 After the len-th accepted beat SHALL enter STREAM next cycle.
REQ-023 STREAM: acc_put and acc_value SHALL be registered outputs, acc_put=1 for exactly len consecutive cycles with acc_value=buffer[0..len-1] in order, no gaps.
REQ-024 DRAIN: acc_put SHALL be 0 for exactly one cycle so the accumulator transfers slots to acc_r0..r2.
REQ-025 CAPTURE: SHALL register acc_r0..r2 into op_a..op_c at the end of the cycle; slots at index >= len forced to 0.
REQ-026 PRESENT: op_valid SHALL be high with op_count=len, op_src=grant; outputs held stable until op_valid&op_ready, then IDLE.
REQ-027 acc_put SHALL be 0 in all states except STREAM; acc_value SHALL be 0 when acc_put=0.
REQ-028 Latency with continuous reqN_valid and op_ready: op_valid high in cycle 2*len+3 after the IDLE cycle that grants.
REQ-029 Requests arriving while busy SHALL be held off (ready low) and arbitrated on return to IDLE; no request dropped.
REQ-030 Simultaneous op_ready and new request in the PRESENT exit cycle: new grant SHALL occur in the following IDLE cycle (one idle cycle minimum between sets).

Reset
REQ-031 reset=0 at a posedge SHALL force IDLE, acc_put=0, acc_value=0, reqN_ready=0, op_valid=0, op_a..op_c=0, op_count=0, op_src=0, busy=0, priority to requester 0.
REQ-032 Reset in any state SHALL abandon the transaction; buffered operands are discarded, not streamed.

Verification
REQ-033 req0 len=3 data 0x11,0x22,0x33 back-to-back -> acc_put high 3 cycles with 0x11,0x22,0x33, then one low cycle; op_a/b/c=0x11/0x22/0x33, op_count=3, op_src=0, op_valid in cycle 9.
REQ-034 req0 and req1 both valid in IDLE after reset -> req0 granted first, then req1; repeated contention alternates 0,1,0,1.
REQ-035 req1 len=1 data 0xA5, acc_r1/acc_r2 driven 0xFF -> op_a=0xA5, op_b=op_c=0, op_count=1.
REQ-036 req0 len=2 with 3-cycle valid gap between beats -> acc_put still high exactly 2 consecutive cycles.
REQ-037 op_ready low 5 cycles in PRESENT -> op_* stable, req ready low throughout; release -> IDLE next cycle.
REQ-038 reset low during STREAM -> next cycle acc_put=0, busy=0, op_valid never asserts for that transaction.

Source files
------------

// File: rtl/accum_sched.sv
// accum_sched: two-requester round-robin scheduler that loads 1-3 operands,
// streams them into an external 3-slot accumulator, captures the slot
// outputs and presents them as one operand set to a downstream consumer.
module accum_sched #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_len,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_len,
    output logic              acc_put,
    output logic [DATA_W-1:0] acc_value,
    input  logic [DATA_W-1:0] acc_r0,
    input  logic [DATA_W-1:0] acc_r1,
    input  logic [DATA_W-1:0] acc_r2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_c,
    output logic [1:0]        op_count,
    output logic              op_src,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STREAM, DRAIN, CAPTURE, PRESENT
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;      // requester that wins a tie
    logic [1:0]        len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;        // load slot / stream index
    logic [DATA_W-1:0] buf_q [3];
    logic [DATA_W-1:0] buf_d [3];
    logic              acc_put_q, acc_put_d;
    logic [DATA_W-1:0] acc_value_q, acc_value_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [1:0]        op_count_q, op_count_d;
    logic              op_src_q, op_src_d;

    logic              win;
    logic [1:0]        win_len;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;

    assign sel_valid  = grant_q ? req1_valid : req0_valid;
    assign sel_data   = grant_q ? req1_data  : req0_data;
    assign req0_ready = (state_q == LOAD) && !grant_q;
    assign req1_ready = (state_q == LOAD) &&  grant_q;
    assign busy       = (state_q != IDLE);
    assign op_valid   = (state_q == PRESENT);
    assign acc_put    = acc_put_q;
    assign acc_value  = acc_value_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_c       = op_c_q;
    assign op_count   = op_count_q;
    assign op_src     = op_src_q;

    // Next-state, arbitration, buffering and registered-output computation.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        acc_put_d   = 1'b0;
        acc_value_d = '0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_count_d  = op_count_q;
        op_src_d    = op_src_q;
        win         = (req0_valid && req1_valid) ? prio_q : req1_valid;
        win_len     = win ? req1_len : req0_len;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = win;
                    prio_d  = ~win;
                    len_d   = (win_len == 2'd0) ? 2'd1 : win_len;
                    cnt_d   = 2'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid) begin
                    buf_d[cnt_q] = sel_data;
                    if (cnt_q == len_q - 2'd1) begin
                        // First put is registered on the way into STREAM so
                        // the put burst starts exactly with the state.
                        cnt_d       = 2'd0;
                        acc_put_d   = 1'b1;
                        acc_value_d = buf_d[0];
                        state_d     = STREAM;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            STREAM: begin
                if (cnt_q == len_q - 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = DRAIN;
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    acc_put_d   = 1'b1;
                    acc_value_d = buf_q[cnt_q + 2'd1];
                end
            end
            DRAIN: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Slots beyond the transaction length hold stale data; zero them.
                op_a_d     = acc_r0;
                op_b_d     = (len_q >= 2'd2) ? acc_r1 : '0;
                op_c_d     = (len_q == 2'd3) ? acc_r2 : '0;
                op_count_d = len_q;
                op_src_d   = grant_q;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (op_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            len_q       <= 2'd1;
            cnt_q       <= 2'd0;
            buf_q       <= '{default: '0};
            acc_put_q   <= 1'b0;
            acc_value_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_count_q  <= 2'd0;
            op_src_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            acc_put_q   <= acc_put_d;
            acc_value_q <= acc_value_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_count_q  <= op_count_d;
            op_src_q    <= op_src_d;
        end
    end

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched: table of single-requester transactions
// plus hand-written sequences for back-pressure, reset mid-stream and contention.
module tb_accum_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [1:0] req0_len, req1_len;
    logic       acc_put;
    logic [7:0] acc_value, acc_r0, acc_r1, acc_r2;
    logic       op_valid, op_ready, op_src, busy;
    logic [7:0] op_a, op_b, op_c;
    logic [1:0] op_count;

    accum_sched #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_len(req1_len),
        .acc_put(acc_put), .acc_value(acc_value),
        .acc_r0(acc_r0), .acc_r1(acc_r1), .acc_r2(acc_r2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .op_count(op_count), .op_src(op_src), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accumulator model: puts fill slots in order; a new burst presets the
    // unused slots to 0xFF so the DUT must zero them itself.
    logic [7:0] slot [3] = '{default: 8'hFF};
    int         wr = 0;
    assign acc_r0 = slot[0];
    assign acc_r1 = slot[1];
    assign acc_r2 = slot[2];

    always @(posedge clk) begin
        if (!reset) begin
            wr <= 0;
        end else if (acc_put) begin
            if (wr == 0) begin
                slot[0] <= acc_value;
                slot[1] <= 8'hFF;
                slot[2] <= 8'hFF;
            end else begin
                slot[wr] <= acc_value;
            end
            wr <= wr + 1;
        end else begin
            wr <= 0;
        end
    end

    // Put monitor: record every streamed value and the length of each burst.
    logic [7:0] putq [$];
    int         run = 0, last_run = 0, bad_val = 0;

    always @(negedge clk) begin
        if (acc_put) begin
            putq.push_back(acc_value);
            run <= run + 1;
        end else begin
            if (acc_value !== 8'h00) bad_val <= bad_val + 1;
            if (run != 0) last_run <= run;
            run <= 0;
        end
    end

    task automatic drive(input int src, input logic v, input logic [7:0] d, input logic [1:0] l);
        if (src == 0) begin
            req0_valid = v; req0_data = d; req0_len = l;
        end else begin
            req1_valid = v; req1_data = d; req1_len = l;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? req0_ready : req1_ready;
    endfunction

    // One transaction from a single requester; returns at the first negedge
    // with op_valid high, lat = cycles since the granting IDLE cycle.
    task automatic run_txn(input int src, input logic [1:0] len,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int gap, output int lat);
        logic [7:0] d [3];
        int nb, k, guard, base;
        d    = '{d0, d1, d2};
        nb   = (len == 2'd0) ? 1 : int'(len);
        base = putq.size();
        k    = 0;
        drive(src, 1'b1, d[0], len);
        for (int i = 0; i < nb; i++) begin
            guard = 0;
            while (!rdy(src) && guard < 50) begin
                @(negedge clk); k++; guard++;
            end
            if (!rdy(src)) begin
                chk("ready_wait", int'(rdy(src)), 1);
                break;
            end
            if (i == 0) chk("other_ready_in_load", int'(rdy(1 - src)), 0);
            @(negedge clk); k++;
            if (i + 1 < nb) begin
                if (gap > 0) begin
                    drive(src, 1'b0, 8'h00, len);
                    repeat (gap) begin @(negedge clk); k++; end
                end
                drive(src, 1'b1, d[i+1], len);
            end
        end
        drive(src, 1'b0, 8'h00, len);
        guard = 0;
        while (!op_valid && guard < 60) begin
            @(negedge clk); k++; guard++;
        end
        chk("op_valid_seen", int'(op_valid), 1);
        lat = k;
        chk("put_count", putq.size() - base, nb);
        for (int j = 0; j < nb && base + j < putq.size(); j++)
            chk($sformatf("put_value[%0d]", j), int'(putq[base+j]), int'(d[j]));
        chk("put_burst_len", last_run, nb);
    endtask

    typedef struct {
        int         src;
        logic [1:0] len;
        logic [7:0] d0, d1, d2;
        int         gap;
        logic [7:0] ea, eb, ec;
        int         ecnt;
        int         elat;   // -1: latency not checked
    } vec_t;

    vec_t tv [6];

    initial begin
        int lat, guard, hits;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, guard, hits;
        tv[0] = '{0, 2'd3, 8'h11, 8'h22, 8'h33, 0, 8'h11, 8'h22, 8'h33, 3, 9};
        tv[1] = '{1, 2'd1, 8'hA5, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 8'h00, 1, 5};
        tv[2] = '{0, 2'd2, 8'h5A, 8'hC3, 8'h00, 3, 8'h5A, 8'hC3, 8'h00, 2, -1};
        tv[3] = '{1, 2'd0, 8'h7E, 8'h00, 8'h00, 0, 8'h7E, 8'h00, 8'h00, 1, 5};
        tv[4] = '{1, 2'd2, 8'h01, 8'h80, 8'h00, 0, 8'h01, 8'h80, 8'h00, 2, 7};
        tv[5] = '{0, 2'd3, 8'hFF, 8'h00, 8'h80, 1, 8'hFF, 8'h00, 8'h80, 3, -1};

        reset = 1'b0;
        op_ready = 1'b1;
        drive(0, 1'b0, 8'h00, 2'd0);
        drive(1, 1'b0, 8'h00, 2'd0);
        repeat (3) @(negedge clk);
        chk("rst_acc_put", int'(acc_put), 0);
        chk("rst_acc_value", int'(acc_value), 0);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
        chk("rst_op_valid", int'(op_valid), 0);
        chk("rst_op_abc", int'({op_a, op_b, op_c}), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_op_src", int'(op_src), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven single-requester transactions.
        for (int i = 0; i < 6; i++) begin
            run_txn(tv[i].src, tv[i].len, tv[i].d0, tv[i].d1, tv[i].d2, tv[i].gap, lat);
            chk($sformatf("v%0d_op_a", i), int'(op_a), int'(tv[i].ea));
            chk($sformatf("v%0d_op_b", i), int'(op_b), int'(tv[i].eb));
            chk($sformatf("v%0d_op_c", i), int'(op_c), int'(tv[i].ec));
            chk($sformatf("v%0d_op_count", i), int'(op_count), tv[i].ecnt);
            chk($sformatf("v%0d_op_src", i), int'(op_src), tv[i].src);
            if (tv[i].elat > 0) chk($sformatf("v%0d_latency", i), lat, tv[i].elat);
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), int'(busy), 0);
        end

        // Back-pressure in PRESENT with a competing request held off.
        op_ready = 1'b0;
        run_txn(0, 2'd1, 8'h42, 8'h00, 8'h00, 0, lat);
        chk("hold_op_a_first", int'(op_a), 8'h42);
        drive(1, 1'b1, 8'h99, 2'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_op_valid", int'(op_valid), 1);
            chk("hold_op_a", int'(op_a), 8'h42);
            chk("hold_op_count", int'(op_count), 1);
            chk("hold_req0_ready", int'(req0_ready), 0);
            chk("hold_req1_ready", int'(req1_ready), 0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        chk("release_idle", int'(busy), 0);
        chk("release_op_valid", int'(op_valid), 0);
        @(negedge clk);
        chk("held_req_granted", int'(req1_ready), 1);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 2'd1);
        guard = 0;
        while (!op_valid && guard < 40) begin @(negedge clk); guard++; end
        chk("held_req_op_valid", int'(op_valid), 1);
        chk("held_req_op_a", int'(op_a), 8'h99);
        chk("held_req_op_src", int'(op_src), 1);
        @(negedge clk);

        // Reset during STREAM abandons the transaction.
        drive(0, 1'b1, 8'h01, 2'd3);
        guard = 0;
        while (!acc_put && guard < 20) begin @(negedge clk); guard++; end
        chk("stream_started", int'(acc_put), 1);
        reset = 1'b0;
        drive(0, 1'b0, 8'h00, 2'd3);
        @(negedge clk);
        chk("mid_rst_acc_put", int'(acc_put), 0);
        chk("mid_rst_acc_value", int'(acc_value), 0);
        chk("mid_rst_busy", int'(busy), 0);
        reset = 1'b1;
        hits = 0;
        repeat (15) begin
            @(negedge clk);
            if (op_valid) hits++;
        end
        chk("abandoned_op_valid_cycles", hits, 0);

        // Contention: both requesters held valid, grants alternate from 0.
        drive(0, 1'b1, 8'h10, 2'd1);
        drive(1, 1'b1, 8'h20, 2'd1);
        for (int s = 0; s < 4; s++) begin
            guard = 0;
            while (!op_valid && guard < 40) begin @(negedge clk); guard++; end
            chk($sformatf("rr%0d_op_valid", s), int'(op_valid), 1);
            chk($sformatf("rr%0d_op_src", s), int'(op_src), s % 2);
            chk($sformatf("rr%0d_op_a", s), int'(op_a), (s % 2) ? 8'h20 : 8'h10);
            if (s == 3) begin
                drive(0, 1'b0, 8'h00, 2'd1);
                drive(1, 1'b0, 8'h00, 2'd1);
            end
            @(negedge clk);
            chk($sformatf("rr%0d_idle_gap", s), int'(busy), 0);
        end

        chk("acc_value_zero_when_idle", bad_val, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
